// File: rtl/qbert_pyramid_map_if.sv
// Pixel/game-logic bundle for the pyramid renderer: VGA counters in, RGB out,
// plus the hop/clear event bus from game logic.
interface qbert_pyramid_map_if;
    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;
    logic        de_in;
    logic        hop_valid;
    logic [2:0]  hop_row;
    logic [2:0]  hop_col;
    logic        level_clear;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        de_out;
    logic        hop_err;
    logic        board_done;

    modport master (
        output x_cnt, y_cnt, de_in, hop_valid, hop_row, hop_col, level_clear,
        input  red, green, blue, de_out, hop_err, board_done
    );

    modport slave (
        input  x_cnt, y_cnt, de_in, hop_valid, hop_row, hop_col, level_clear,
        output red, green, blue, de_out, hop_err, board_done
    );
endinterface

// File: rtl/qbert_pyramid_map.sv
// Q*bert pyramid renderer: per-cube top-face levels driven by hop events,
// three-stage pixel pipeline from VGA counters to RGB.
module qbert_pyramid_map #(
    parameter int          N_ROWS      = 3,
    parameter logic [10:0] HALF_W      = 11'd30,
    parameter logic [9:0]  TOP_H       = 10'd25,
    parameter logic [9:0]  SIDE_H      = 10'd35,
    parameter logic [9:0]  ROW_H       = 10'd60,
    parameter logic [10:0] ORIGIN_X    = 11'd400,
    parameter logic [9:0]  ORIGIN_Y    = 10'd100,
    parameter int          COLOR_STEPS = 3,
    parameter int          WRAP_MODE   = 0,
    parameter logic [23:0] TOP_COL0    = 24'h5646EF,
    parameter logic [23:0] TOP_COL1    = 24'hDEDE00,
    parameter logic [23:0] TOP_COL2    = 24'hEF4656,
    parameter logic [23:0] LEFT_COL    = 24'h56A998,
    parameter logic [23:0] RIGHT_COL   = 24'h314646
) (
    input logic               clk,
    input logic               reset,
    qbert_pyramid_map_if.slave bus
);
    localparam int N_CUBES = N_ROWS * (N_ROWS + 1) / 2;
    localparam logic [1:0] MAX_LVL = 2'(COLOR_STEPS - 1);
    localparam logic signed [23:0] HW  = 24'(HALF_W);
    localparam logic signed [23:0] NHW = -24'(HALF_W);
    localparam logic signed [23:0] TH  = 24'(TOP_H);
    localparam logic signed [23:0] TH2 = 24'(TOP_H) * 24'sd2;
    localparam logic signed [23:0] SH  = 24'(SIDE_H);

    typedef enum logic [1:0] {FACE_NONE, FACE_TOP, FACE_LEFT, FACE_RIGHT} face_t;

    logic signed [11:0] dx_q [N_CUBES];
    logic signed [11:0] dy_q [N_CUBES];
    logic               de_s1, de_s2;
    face_t              face_s2, win_face, cube_face;
    logic [1:0]         lvl_s2, win_lvl;
    logic [1:0]         level     [N_CUBES];
    logic [1:0]         level_nxt [N_CUBES];
    logic [5:0]         done_cnt, done_nxt;
    logic               hop_hit, hop_err_nxt;
    logic [23:0]        rgb_nxt;

    function automatic face_t face_of(input logic signed [11:0] dx12, input logic signed [11:0] dy12);
        logic signed [23:0] x, y, ax, ay, lx, rx;
        x  = {{12{dx12[11]}}, dx12};
        y  = {{12{dy12[11]}}, dy12};
        ax = x[23] ? -x : x;
        ay = (y < TH) ? (TH - y) : (y - TH);
        lx = x + HW;
        rx = HW - x;
        face_of = FACE_NONE;
        if (!y[23] && y <= TH2 && (ax * TH + ay * HW) <= HW * TH)
            face_of = FACE_TOP;
        else if (x[23] && x >= NHW && (y - TH) * HW >= lx * TH && (y - TH - SH) * HW < lx * TH)
            face_of = FACE_LEFT;
        else if (!x[23] && x < HW && (y - TH) * HW >= rx * TH && (y - TH - SH) * HW < rx * TH)
            face_of = FACE_RIGHT;
    endfunction

    // S1: cube-relative offsets, cubes indexed row-major (r*(r+1)/2 + c)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CUBES; i++) begin
                dx_q[i] <= '0;
                dy_q[i] <= '0;
            end
            de_s1 <= 1'b0;
        end else begin
            for (int r = 0; r < N_ROWS; r++)
                for (int c = 0; c <= r; c++) begin
                    dx_q[r*(r+1)/2+c] <= {1'b0, bus.x_cnt}
                        - 12'(int'(ORIGIN_X) + (2*c - r) * int'(HALF_W));
                    dy_q[r*(r+1)/2+c] <= {2'b0, bus.y_cnt}
                        - 12'(int'(ORIGIN_Y) + r * int'(ROW_H));
                end
            de_s1 <= bus.de_in;
        end
    end

    // Later index wins: front row beats back row; within a row the right cube wins a shared vertex
    always_comb begin
        win_face  = FACE_NONE;
        win_lvl   = 2'd0;
        cube_face = FACE_NONE;
        for (int i = 0; i < N_CUBES; i++) begin
            cube_face = face_of(dx_q[i], dy_q[i]);
            if (cube_face != FACE_NONE) begin
                win_face = cube_face;
                win_lvl  = level[i];
            end
        end
    end

    always_comb begin
        rgb_nxt = 24'h000000;
        if (de_s2) begin
            case (face_s2)
                FACE_TOP:   rgb_nxt = (lvl_s2 == 2'd0) ? TOP_COL0 :
                                      (lvl_s2 == 2'd1) ? TOP_COL1 : TOP_COL2;
                FACE_LEFT:  rgb_nxt = LEFT_COL;
                FACE_RIGHT: rgb_nxt = RIGHT_COL;
                default:    rgb_nxt = 24'h000000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            face_s2    <= FACE_NONE;
            lvl_s2     <= 2'd0;
            de_s2      <= 1'b0;
            bus.red    <= 8'd0;
            bus.green  <= 8'd0;
            bus.blue   <= 8'd0;
            bus.de_out <= 1'b0;
        end else begin
            face_s2    <= win_face;
            lvl_s2     <= win_lvl;
            de_s2      <= de_s1;
            bus.red    <= rgb_nxt[23:16];
            bus.green  <= rgb_nxt[15:8];
            bus.blue   <= rgb_nxt[7:0];
            bus.de_out <= de_s2;
        end
    end

    // Level bookkeeping; clear beats a coincident hop
    always_comb begin
        hop_hit  = 1'b0;
        done_nxt = done_cnt;
        for (int i = 0; i < N_CUBES; i++) level_nxt[i] = level[i];
        if (bus.level_clear) begin
            done_nxt = 6'd0;
            for (int i = 0; i < N_CUBES; i++) level_nxt[i] = 2'd0;
        end else if (bus.hop_valid) begin
            for (int r = 0; r < N_ROWS; r++)
                for (int c = 0; c <= r; c++)
                    if (bus.hop_row == 3'(r) && bus.hop_col == 3'(c)) begin
                        hop_hit = 1'b1;
                        if (level[r*(r+1)/2+c] != MAX_LVL) begin
                            level_nxt[r*(r+1)/2+c] = level[r*(r+1)/2+c] + 2'd1;
                            if (level[r*(r+1)/2+c] + 2'd1 == MAX_LVL) done_nxt = done_cnt + 6'd1;
                        end else if (WRAP_MODE != 0) begin
                            level_nxt[r*(r+1)/2+c] = 2'd0;
                            done_nxt = done_cnt - 6'd1;
                        end
                    end
        end
        hop_err_nxt = bus.hop_valid && !bus.level_clear && !hop_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CUBES; i++) level[i] <= 2'd0;
            done_cnt       <= 6'd0;
            bus.hop_err    <= 1'b0;
            bus.board_done <= 1'b0;
        end else begin
            for (int i = 0; i < N_CUBES; i++) level[i] <= level_nxt[i];
            done_cnt       <= done_nxt;
            bus.hop_err    <= hop_err_nxt;
            bus.board_done <= (done_nxt == 6'(N_CUBES));
        end
    end
endmodule

// File: tb/tb_qbert_pyramid_map.sv
// Bench for qbert_pyramid_map: saturating and wrapping instances checked every
// cycle against a geometric reference model, plus directed spec scenarios.
module tb_qbert_pyramid_map;
    localparam int NR = 3;
    localparam int NC = NR * (NR + 1) / 2;
    localparam int MAXL = 2;
    localparam int HWI = 30, THI = 25, SHI = 35, RHI = 60, OXI = 400, OYI = 100;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   lv0 [NC];
    int   lv1 [NC];
    logic [24:0] p0 [3];
    logic [24:0] p1 [3];

    qbert_pyramid_map_if bus ();
    qbert_pyramid_map_if bus_w ();

    assign bus_w.x_cnt       = bus.x_cnt;
    assign bus_w.y_cnt       = bus.y_cnt;
    assign bus_w.de_in       = bus.de_in;
    assign bus_w.hop_valid   = bus.hop_valid;
    assign bus_w.hop_row     = bus.hop_row;
    assign bus_w.hop_col     = bus.hop_col;
    assign bus_w.level_clear = bus.level_clear;

    qbert_pyramid_map #(.WRAP_MODE(0)) dut   (.clk(clk), .reset(reset), .bus(bus));
    qbert_pyramid_map #(.WRAP_MODE(1)) dut_w (.clk(clk), .reset(reset), .bus(bus_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Expected {de_out, rgb} for a pixel given the model levels of one instance
    function automatic logic [24:0] model_pix(input int x, input int y, input logic de, input int m);
        int wf, wi, idx, f, dx, dy, lvl;
        wf = 0; wi = 0; idx = 0;
        if (!de) return 25'd0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c <= r; c++) begin
                dx = x - (OXI + (2*c - r) * HWI);
                dy = y - (OYI + r * RHI);
                f = 0;
                if (dy >= 0 && dy <= 2*THI && iabs(dx)*THI + iabs(dy - THI)*HWI <= HWI*THI) f = 1;
                else if (dx >= -HWI && dx <= -1 && (dy-THI)*HWI >= (dx+HWI)*THI
                         && (dy-THI-SHI)*HWI < (dx+HWI)*THI) f = 2;
                else if (dx >= 0 && dx <= HWI-1 && (dy-THI)*HWI >= (HWI-dx)*THI
                         && (dy-THI-SHI)*HWI < (HWI-dx)*THI) f = 3;
                if (f != 0) begin wf = f; wi = idx; end
                idx++;
            end
        lvl = (m == 0) ? lv0[wi] : lv1[wi];
        case (wf)
            1:       return {1'b1, (lvl == 0) ? 24'h5646EF : (lvl == 1) ? 24'hDEDE00 : 24'hEF4656};
            2:       return {1'b1, 24'h56A998};
            3:       return {1'b1, 24'h314646};
            default: return {1'b1, 24'h000000};
        endcase
    endfunction

    function automatic logic all_max(input int m);
        for (int i = 0; i < NC; i++)
            if (((m == 0) ? lv0[i] : lv1[i]) != MAXL) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NC; i++) begin lv0[i] = 0; lv1[i] = 0; end
        for (int i = 0; i < 3; i++) begin p0[i] = '0; p1[i] = '0; end
    endtask

    task automatic tick();
        logic he;
        int r, c, idx;
        @(posedge clk);
        he = 1'b0;
        if (bus.level_clear) begin
            for (int i = 0; i < NC; i++) begin lv0[i] = 0; lv1[i] = 0; end
        end else if (bus.hop_valid) begin
            r = int'(bus.hop_row);
            c = int'(bus.hop_col);
            if (r < NR && c <= r) begin
                idx = r*(r+1)/2 + c;
                if (lv0[idx] < MAXL) lv0[idx]++;
                lv1[idx] = (lv1[idx] == MAXL) ? 0 : lv1[idx] + 1;
            end else he = 1'b1;
        end
        p0[2] = p0[1]; p0[1] = p0[0];
        p0[0] = model_pix(int'(bus.x_cnt), int'(bus.y_cnt), bus.de_in, 0);
        p1[2] = p1[1]; p1[1] = p1[0];
        p1[0] = model_pix(int'(bus.x_cnt), int'(bus.y_cnt), bus.de_in, 1);
        #1;
        chk("rgb_sat",   {8'h0, bus.red, bus.green, bus.blue},       {8'h0, p0[2][23:0]});
        chk("de_sat",    {31'h0, bus.de_out},                        {31'h0, p0[2][24]});
        chk("err_sat",   {31'h0, bus.hop_err},                       {31'h0, he});
        chk("done_sat",  {31'h0, bus.board_done},                    {31'h0, all_max(0)});
        chk("rgb_wrap",  {8'h0, bus_w.red, bus_w.green, bus_w.blue}, {8'h0, p1[2][23:0]});
        chk("de_wrap",   {31'h0, bus_w.de_out},                      {31'h0, p1[2][24]});
        chk("err_wrap",  {31'h0, bus_w.hop_err},                     {31'h0, he});
        chk("done_wrap", {31'h0, bus_w.board_done},                  {31'h0, all_max(1)});
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic de,
                       input logic [23:0] e0, input logic [23:0] e1);
        bus.x_cnt = 11'(x); bus.y_cnt = 10'(y); bus.de_in = de;
        tick(); tick(); tick();
        chk({tag, "_sat"},  {8'h0, bus.red, bus.green, bus.blue},       {8'h0, e0});
        chk({tag, "_wrap"}, {8'h0, bus_w.red, bus_w.green, bus_w.blue}, {8'h0, e1});
        chk({tag, "_de"},   {31'h0, bus.de_out},                        {31'h0, de});
    endtask

    task automatic hop(input int r, input int c);
        bus.hop_valid = 1'b1; bus.hop_row = 3'(r); bus.hop_col = 3'(c);
        tick();
        bus.hop_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rgb"},  {8'h0, bus.red, bus.green, bus.blue, bus_w.red, bus_w.green, bus_w.blue} == 56'h0 ? 32'h0 : 32'h1, 32'h0);
        chk({tag, "_de"},   {30'h0, bus.de_out, bus_w.de_out},         32'h0);
        chk({tag, "_err"},  {30'h0, bus.hop_err, bus_w.hop_err},       32'h0);
        chk({tag, "_done"}, {30'h0, bus.board_done, bus_w.board_done}, 32'h0);
    endtask

    initial begin
        checks = 0; errors = 0;
        bus.x_cnt = '0; bus.y_cnt = '0; bus.de_in = 1'b0;
        bus.hop_valid = 1'b0; bus.hop_row = '0; bus.hop_col = '0; bus.level_clear = 1'b0;
        model_clear();
        reset = 1'b0;
        #12;
        chk_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        pix("top00",   400, 125, 1'b1, 24'h5646EF, 24'h5646EF);
        pix("left00",  385, 150, 1'b1, 24'h56A998, 24'h56A998);
        pix("right00", 415, 150, 1'b1, 24'h314646, 24'h314646);
        pix("bg",       10,  10, 1'b1, 24'h000000, 24'h000000);
        pix("de_off",  400, 125, 1'b0, 24'h000000, 24'h000000);

        bus.de_in = 1'b1;
        hop(0, 0);
        pix("lvl1", 400, 125, 1'b1, 24'hDEDE00, 24'hDEDE00);
        hop(0, 0);
        pix("lvl2", 400, 125, 1'b1, 24'hEF4656, 24'hEF4656);
        hop(0, 0);
        pix("lvl3", 400, 125, 1'b1, 24'hEF4656, 24'h5646EF);

        bus.level_clear = 1'b1; tick(); bus.level_clear = 1'b0;
        for (int pass = 0; pass < 2; pass++)
            for (int r = 0; r < NR; r++)
                for (int c = 0; c <= r; c++) hop(r, c);
        chk("board_done_set", {31'h0, bus.board_done}, 32'h1);
        bus.level_clear = 1'b1; tick(); bus.level_clear = 1'b0;
        chk("board_done_clr", {31'h0, bus.board_done}, 32'h0);
        pix("top_clr", 400, 125, 1'b1, 24'h5646EF, 24'h5646EF);
        pix("top_r2c1", 400, 245, 1'b1, 24'h5646EF, 24'h5646EF);

        hop(1, 2);
        chk("hop_err_c_gt_r", {31'h0, bus.hop_err}, 32'h1);
        hop(3, 0);
        chk("hop_err_row", {31'h0, bus.hop_err}, 32'h1);
        tick();
        chk("hop_err_pulse", {31'h0, bus.hop_err}, 32'h0);
        hop(0, 0);
        bus.hop_valid = 1'b1; bus.hop_row = 3'd0; bus.hop_col = 3'd0; bus.level_clear = 1'b1;
        tick();
        bus.hop_valid = 1'b0; bus.level_clear = 1'b0;
        chk("clear_beats_hop", {31'h0, bus.hop_err}, 32'h0);
        pix("after_clear_hop", 400, 125, 1'b1, 24'h5646EF, 24'h5646EF);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                bus.x_cnt = 11'($urandom_range(0, 2047));
                bus.y_cnt = 10'($urandom_range(0, 1023));
            end else begin
                bus.x_cnt = 11'($urandom_range(330, 470));
                bus.y_cnt = 10'($urandom_range(90, 310));
            end
            bus.de_in       = ($urandom_range(0, 9) != 0);
            bus.hop_valid   = ($urandom_range(0, 5) == 0);
            bus.hop_row     = 3'($urandom_range(0, 3));
            bus.hop_col     = 3'($urandom_range(0, 3));
            bus.level_clear = ($urandom_range(0, 80) == 0);
            tick();
        end
        bus.hop_valid = 1'b0; bus.level_clear = 1'b0;

        for (int r = 0; r < NR; r++) for (int c = 0; c <= r; c++) begin hop(r, c); hop(r, c); end
        bus.x_cnt = 11'd400; bus.y_cnt = 10'd125; bus.de_in = 1'b1;
        tick(); tick(); tick();
        #3 reset = 1'b0;
        #1;
        chk_zero("reset_mid");
        model_clear();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        pix("post_reset", 400, 125, 1'b1, 24'h5646EF, 24'h5646EF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
